// File: rtl/tinybf_pkg.sv
// Shared TinyBF definitions: opcode encodings, HALT word, boot image length
// and the program store sequencing states.
package tinybf_pkg;

  localparam logic [2:0] OP_RIGHT = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_OUT   = 3'b100;
  localparam logic [2:0] OP_IN    = 3'b101;
  localparam logic [2:0] OP_JNZ   = 3'b111;

  // HALT is the all-zero word at any instruction width.
  localparam int HALT     = 0;
  localparam int BOOT_LEN = 7;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_FILL
  } state_t;

endpackage

// File: rtl/bf_boot_rom.sv
// Built-in TinyBF boot program as a combinational lookup by word address.
// Operands are two's complement in the low DATA_W-3 bits.
module bf_boot_rom
  import tinybf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic [AW-1:0]     addr_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int OW = DATA_W - 3;

  always_comb begin
    data_o = DATA_W'(HALT);
    case (int'(addr_i))
      0: data_o = {OP_INC,   OW'(5)};
      1: data_o = {OP_OUT,   OW'(0)};
      2: data_o = {OP_RIGHT, OW'(1)};
      3: data_o = {OP_INC,   OW'(3)};
      4: data_o = {OP_OUT,   OW'(0)};
      5: data_o = {OP_JNZ,   OW'(-5)};
      6: data_o = {OP_IN,    OW'(0)};
      default: data_o = DATA_W'(HALT);
    endcase
  end

endmodule

// File: rtl/program_store.sv
// TinyBF instruction memory: boot-image self-init, streaming loader with
// HALT fill, program length and overflow reporting, one write-first read port.
//
// state | meaning
// INIT  | writing boot image, one word per cycle
// IDLE  | direct writes accepted, waiting for ld_start_i
// LOAD  | accepting loader words at the auto-increment pointer
// FILL  | writing HALT from end of program to last word
module program_store
  import tinybf_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wen_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              ren_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              busy_o,
  output logic [AW:0]       prog_len_o,
  output logic              ld_ovf_o
);

  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_P  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] BOOT_P  = (AW+1)'(BOOT_LEN);
  localparam logic [AW:0] ONE_P   = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [AW:0]       ptr;
  logic [DATA_W-1:0] boot_word;
  logic              we;
  logic [AW-1:0]     wa;
  logic [DATA_W-1:0] wd;
  logic              accept;
  logic              room;
  logic [AW:0]       written;

  bf_boot_rom #(.DATA_W(DATA_W), .AW(AW)) u_boot_rom (
    .addr_i (ptr[AW-1:0]),
    .data_o (boot_word)
  );

  assign accept  = ld_valid_i & ld_ready_o;
  assign room    = ptr < DEPTH_P;
  // Words written so far including the one being accepted; saturates at DEPTH.
  assign written = room ? ptr + ONE_P : ptr;

  always_comb begin
    we = 1'b0;
    wa = ptr[AW-1:0];
    wd = ld_data_i;
    case (state)
      ST_INIT: begin
        we = 1'b1;
        wd = boot_word;
      end
      ST_IDLE: begin
        we = wen_i & ~ld_start_i;
        wa = waddr_i;
        wd = wdata_i;
      end
      ST_LOAD: we = accept & room;
      ST_FILL: begin
        we = 1'b1;
        wd = DATA_W'(HALT);
      end
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (we) mem[wa] <= wd;
  end

  // Write-first: a same-cycle write to the read address bypasses the array.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     rdata_o <= '0;
    else if (ren_i) rdata_o <= (we && wa == raddr_i) ? wd : mem[raddr_i];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_INIT;
      ptr        <= '0;
      busy_o     <= 1'b1;
      ld_ready_o <= 1'b0;
      prog_len_o <= '0;
      ld_ovf_o   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (ptr == LAST_P) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            busy_o     <= 1'b0;
            prog_len_o <= BOOT_P;
          end else begin
            ptr <= ptr + ONE_P;
          end
        end
        ST_IDLE: begin
          if (ld_start_i) begin
            state      <= ST_LOAD;
            ptr        <= '0;
            ld_ovf_o   <= 1'b0;
            ld_ready_o <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (!room) ld_ovf_o <= 1'b1;
            ptr <= written;
            if (ld_last_i) begin
              prog_len_o <= written;
              ld_ready_o <= 1'b0;
              if (written < DEPTH_P) begin
                state <= ST_FILL;
              end else begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
              end
            end
          end
        end
        ST_FILL: begin
          if (ptr == LAST_P) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            ptr <= ptr + ONE_P;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_program_store.sv
// Bench for program_store: a memory-level reference model checked every
// cycle, directed scenarios with literal expectations, and randomized traffic.
module tb_program_store;

  localparam int DW = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          wen_i = 1'b0;
  logic [AW-1:0] waddr_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic          ren_i = 1'b0;
  logic [AW-1:0] raddr_i = '0;
  logic [DW-1:0] rdata_o;
  logic          ld_start_i = 1'b0;
  logic          ld_valid_i = 1'b0;
  logic [DW-1:0] ld_data_i = '0;
  logic          ld_last_i = 1'b0;
  logic          ld_ready_o;
  logic          busy_o;
  logic [AW:0]   prog_len_o;
  logic          ld_ovf_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  program_store #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wen_i      (wen_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .ren_i      (ren_i),
    .raddr_i    (raddr_i),
    .rdata_o    (rdata_o),
    .ld_start_i (ld_start_i),
    .ld_valid_i (ld_valid_i),
    .ld_data_i  (ld_data_i),
    .ld_last_i  (ld_last_i),
    .ld_ready_o (ld_ready_o),
    .busy_o     (busy_o),
    .prog_len_o (prog_len_o),
    .ld_ovf_o   (ld_ovf_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Boot word from opcode and signed operand.
  function automatic logic [DW-1:0] enc(input logic [2:0] op, input int v);
    logic [DW-4:0] o;
    o = v[DW-4:0];
    return {op, o};
  endfunction

  function automatic logic [DW-1:0] boot_word(input int a);
    case (a)
      0: return enc(3'b010, 5);
      1: return enc(3'b100, 0);
      2: return enc(3'b000, 1);
      3: return enc(3'b010, 3);
      4: return enc(3'b100, 0);
      5: return enc(3'b111, -5);
      6: return enc(3'b101, 0);
      default: return '0;
    endcase
  endfunction

  // Reference model: memory image plus the remaining work of each activity.
  logic [DW-1:0] mm [D];
  bit            known [D];
  logic [DW-1:0] e_rdata;
  bit            e_rknown, e_ready, e_busy, e_ovf, loading;
  int            e_len, boot_left, fill_left, wr_cnt;
  bit            live = 1'b0;
  bit            rand_rd = 1'b0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      e_rdata = '0; e_rknown = 1'b1; e_ready = 1'b0; e_busy = 1'b1;
      e_len = 0; e_ovf = 1'b0; boot_left = D; fill_left = 0;
      loading = 1'b0; wr_cnt = 0;
      foreach (known[i]) known[i] = 1'b0;
    end else begin : step
      bit w;
      int wa;
      logic [DW-1:0] wd;
      w = 1'b0; wa = 0; wd = '0;
      if (boot_left > 0) begin
        w = 1'b1; wa = D - boot_left; wd = boot_word(wa);
        boot_left--;
        if (boot_left == 0) begin e_len = 7; e_busy = 1'b0; end
      end else if (fill_left > 0) begin
        w = 1'b1; wa = D - fill_left; wd = '0;
        fill_left--;
        if (fill_left == 0) e_busy = 1'b0;
      end else if (loading) begin
        if (ld_valid_i) begin
          if (wr_cnt < D) begin w = 1'b1; wa = wr_cnt; wd = ld_data_i; wr_cnt++; end
          else e_ovf = 1'b1;
          if (ld_last_i) begin
            e_len = wr_cnt; loading = 1'b0; e_ready = 1'b0;
            fill_left = D - wr_cnt;
            if (fill_left == 0) e_busy = 1'b0;
          end
        end
      end else if (ld_start_i) begin
        loading = 1'b1; wr_cnt = 0; e_ovf = 1'b0; e_ready = 1'b1; e_busy = 1'b1;
      end else if (wen_i) begin
        w = 1'b1; wa = int'(waddr_i); wd = wdata_i;
      end
      if (ren_i) begin
        if (w && wa == int'(raddr_i)) begin e_rdata = wd; e_rknown = 1'b1; end
        else begin e_rdata = mm[raddr_i]; e_rknown = known[raddr_i]; end
      end
      if (w) begin mm[wa] = wd; known[wa] = 1'b1; end
    end
  end

  always @(negedge clk_i) begin
    if (live) begin
      chk("busy", busy_o, e_busy);
      chk("ld_ready", ld_ready_o, e_ready);
      chk("prog_len", prog_len_o, e_len);
      chk("ld_ovf", ld_ovf_o, e_ovf);
      if (e_rknown) chk("rdata", rdata_o, e_rdata);
    end
  end

  task automatic tick();
    if (rand_rd) begin
      ren_i   = 1'($urandom_range(0, 1));
      raddr_i = AW'($urandom);
    end
    @(negedge clk_i);
  endtask

  task automatic rd(input int a, input logic [DW-1:0] exp, input string nm);
    ren_i = 1'b1; raddr_i = AW'(a);
    tick();
    ren_i = 1'b0;
    chk(nm, rdata_o, exp);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy_o && k < 100) begin tick(); k++; end
    if (busy_o) chk("idle_timeout", busy_o, 0);
  endtask

  task automatic do_load(input int n, input bit rnd);
    int i = 0;
    int c = 0;
    bit v;
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
    while (i < n && c < 300) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_valid_i = v;
      ld_data_i  = rnd ? DW'($urandom) : DW'(8'h30 + i);
      ld_last_i  = v ? (i == n - 1) : 1'($urandom_range(0, 1));
      wen_i      = rnd & 1'($urandom_range(0, 1));
      waddr_i    = AW'($urandom);
      wdata_i    = DW'($urandom);
      ld_start_i = rnd & 1'($urandom_range(0, 1));
      tick();
      if (v) i++;
      c++;
    end
    ld_valid_i = 1'b0; ld_last_i = 1'b0; wen_i = 1'b0; ld_start_i = 1'b0;
    if (i < n) chk("load_timeout", i, n);
  endtask

  logic [DW-1:0] boot_lit [8] = '{8'h45, 8'h80, 8'h01, 8'h43, 8'h80, 8'hFB, 8'hA0, 8'h00};
  logic [DW-1:0] words3 [3]   = '{8'h11, 8'h22, 8'h33};

  initial begin
    int k;
    int i;
    int c;
    #3 rst_i = 1'b0;
    live = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", busy_o, 1);
    chk("rst_len", prog_len_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_ready", ld_ready_o, 0);
    rst_i = 1'b1;

    // Boot: INIT lasts DEPTH cycles, then the image reads back.
    k = 0;
    while (busy_o && k < 40) begin tick(); k++; end
    chk("init_cycles", k, 16);
    chk("boot_len", prog_len_o, 7);
    for (int a = 0; a < 8; a++) rd(a, boot_lit[a], "boot_word");

    // Direct write with same-cycle read of the same address.
    wen_i = 1'b1; waddr_i = 4'd3; wdata_i = 8'h41; ren_i = 1'b1; raddr_i = 4'd3;
    tick();
    wen_i = 1'b0; ren_i = 1'b0;
    chk("wr_first", rdata_o, 8'h41);
    rd(3, 8'h41, "wr_persist");

    // ld_start_i beats wen_i; wen_i inside LOAD is ignored.
    wen_i = 1'b1; waddr_i = 4'd3; wdata_i = 8'h99; ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
    chk("start_ready", ld_ready_o, 1);
    waddr_i = 4'd4; wdata_i = 8'h77; ren_i = 1'b1; raddr_i = 4'd3;
    tick();
    wen_i = 1'b0; raddr_i = 4'd4;
    chk("start_drops_wen", rdata_o, 8'h41);
    tick();
    ren_i = 1'b0;
    chk("load_ignores_wen", rdata_o, 8'h80);

    // Three words with valid toggling and a stray last without valid.
    i = 0; c = 0;
    while (i < 3 && c < 20) begin
      ld_valid_i = c[0];
      ld_data_i  = words3[i];
      ld_last_i  = (i == 2) || !c[0];
      tick();
      if (c[0]) i++;
      c++;
    end
    ld_valid_i = 1'b0; ld_last_i = 1'b0;
    chk("len3", prog_len_o, 3);
    k = 0;
    while (busy_o && k < 50) begin tick(); k++; end
    chk("fill_cycles", k, 13);
    for (int a = 0; a < 16; a++) rd(a, (a < 3) ? words3[a] : 8'h00, "load3_word");

    // Overflowing load: 18 words, last on the 18th.
    do_load(18, 1'b0);
    chk("ovf_busy", busy_o, 0);
    chk("ovf_flag", ld_ovf_o, 1);
    chk("ovf_len", prog_len_o, 16);
    rd(15, 8'h3F, "ovf_last_word");
    rd(0, 8'h30, "ovf_first_word");

    // Randomized traffic: direct writes and loads of random length.
    rand_rd = 1'b1;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int j = 0; j < 6; j++) begin
          wen_i   = 1'($urandom_range(0, 1));
          waddr_i = AW'($urandom);
          wdata_i = DW'($urandom);
          tick();
        end
        wen_i = 1'b0;
      end else begin
        do_load($urandom_range(1, 20), 1'b1);
      end
      wait_idle();
      tick();
    end
    rand_rd = 1'b0;
    ren_i = 1'b0;

    // Reset in the middle of a load.
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
    ld_valid_i = 1'b1; ld_data_i = 8'h5A;
    tick();
    ld_data_i = 8'h5B;
    tick();
    ld_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("abort_busy", busy_o, 1);
    chk("abort_ready", ld_ready_o, 0);
    chk("abort_len", prog_len_o, 0);
    chk("abort_ovf", ld_ovf_o, 0);
    chk("abort_rdata", rdata_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    k = 0;
    while (busy_o && k < 40) begin tick(); k++; end
    chk("reinit_cycles", k, 16);
    chk("reinit_len", prog_len_o, 7);
    for (int a = 0; a < 8; a++) rd(a, boot_lit[a], "reboot_word");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_store.md
Name: program_store

Overview:
Parametrised successor to the TinyBF instruction memory. It is a synchronous RAM with one read port, holding DEPTH words of DATA_W bits. It self-initialises with a built-in boot image after reset. It adds a streaming program loader (valid/ready, auto-increment, last-marker) that HALT-fills unused locations, reports program length, and flags overflow. It sits between the host/IO loader and the TinyBF core fetch stage.

Parameters:
DATA_W, 8, instruction width. Must be at least 8. Opcode occupies [DATA_W-1:DATA_W-3]; the operand is the low DATA_W-3 bits in two's complement.
DEPTH, 16, number of words. Power of 2, at least 8.
AW, $clog2(DEPTH), address width (derived, not overridable).

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
wen_i  in  1  direct write enable; honoured only in IDLE
waddr_i  in  AW  direct write address
wdata_i  in  DATA_W  direct write data
ren_i  in  1  read enable
raddr_i  in  AW  read address
rdata_o  out  DATA_W  read data, valid 1 cycle after ren_i
ld_start_i  in  1  pulse: begin a program load (IDLE only)
ld_valid_i  in  1  loader word valid
ld_data_i  in  DATA_W  loader word
ld_last_i  in  1  qualifies the final loader word
ld_ready_o  out  1  loader can accept a word (high only in LOAD)
busy_o  out  1  high in INIT, LOAD, FILL
prog_len_o  out  AW+1  number of valid program words (0..DEPTH)
ld_ovf_o  out  1  sticky: load exceeded DEPTH words

Behaviour:
- Reset values: rdata_o=0, ld_ready_o=0, busy_o=1, prog_len_o=0, ld_ovf_o=0. State is INIT with a pointer of 0. Memory contents are undefined until INIT completes.
- FSM states: INIT, IDLE, LOAD, FILL.
- INIT: writes boot_image(ptr) for one word per cycle, ptr 0..DEPTH-1. At ptr==DEPTH-1, go to IDLE and set prog_len_o=7. INIT takes exactly DEPTH cycles. busy_o falls on the first IDLE cycle.
- Boot image, indices 0-6: +5, ., >, +3, ., JNZ -5, ,. All other indices hold HALT (all-zero). Opcode encodings: > =000, + =010, . =100, , =101, JNZ =111. The operand is sign-extended to DATA_W-3 bits, so JNZ -5 with DATA_W=8 is 8'hFB.
- IDLE: wen_i writes mem[waddr_i]. ld_start_i takes priority over wen_i in the same cycle, and that wen_i is dropped. On ld_start_i: ptr=0, ld_ovf_o=0, go to LOAD. ld_ready_o=1 from the next cycle.
- LOAD: a word is accepted when ld_valid_i and ld_ready_o are both high.
  - While ptr<DEPTH: write mem[ptr]=ld_data_i and increment ptr.
  - At ptr==DEPTH: set ld_ovf_o=1 and discard the word. ld_ready_o stays 1 so the stream drains.
  - On an accepted word with ld_last_i=1: prog_len_o = number of words written, including this one, saturating at DEPTH.
  - After last: go to FILL if words written < DEPTH, otherwise go to IDLE.
  - ld_last_i without ld_valid_i is ignored. ld_start_i is ignored in LOAD.
- FILL: writes HALT to mem[ptr] one word per cycle until ptr==DEPTH-1, then goes to IDLE. Duration is DEPTH - prog_len_o cycles.
- wen_i and ld_start_i are ignored in INIT, LOAD and FILL.
- Read port:
  - On ren_i, rdata_o <= mem[raddr_i] next cycle.
  - Write-first: if any write (init, loader, fill or direct) targets raddr_i in the same cycle, rdata_o gets the written data.
  - When ren_i is low, rdata_o holds its value.
  - Reads are allowed in every state.
- Pointer arithmetic is AW+1 bits so that DEPTH is representable. There is no wrap-around of the write address.
- Asserting rst_i mid-LOAD or mid-FILL aborts immediately to INIT. All outputs return to their reset values.

Decomposition:
- Package tinybf_pkg holds:
  - opcode localparams (OP_RIGHT, OP_INC, OP_OUT, OP_IN, OP_JNZ);
  - the HALT constant;
  - the FSM state encoding;
  - BOOT_LEN=7.
- One sub-module: bf_boot_rom, a combinational function of address giving the boot word, parametrised by DATA_W.

Test Plan:
- Reset release, idle inputs -> busy_o low after 16 cycles, prog_len_o=7. Reading addresses 0..7 returns 45,80,01,43,80,FB,A0,00.
- Direct write 8'h41 to address 3 with ren_i on raddr=3 in the same cycle -> rdata_o=41 next cycle, and a later read of 3 returns 41.
- ld_start_i, then 3 words 11,22,33 with last on 33 and valid toggling -> prog_len_o=3. FILL lasts 13 cycles. Addresses 0-2 read 11,22,33 and 3-15 read 00.
- Load of 18 words with last on the 18th -> ld_ovf_o=1, prog_len_o=16, address 15 holds word 16, state goes to IDLE with no FILL.
- ld_start_i and wen_i in the same IDLE cycle -> wen_i target is unchanged and ld_ready_o=1 next cycle. wen_i during LOAD has no effect.
- rst_i asserted after 2 loader words -> outputs reset immediately. After 16 cycles the boot image is restored and prog_len_o=7.
